cond_unit: RTL and testbench

- Consumer end of the ALU flag interface. Holds the architectural NZCV flag register and evaluates the 4-bit instruction condition field against it.
- Gates the decoder's write and branch strobes with the condition result.
- Sits between the decoder/ALU and the register file, memory and PC mux, with one registered output stage and a valid/stall handshake.

---
 rtl/cond_unit_pkg.sv | 29 ++
 rtl/cond_unit_if.sv | 32 +++
 rtl/cond_unit_check.sv | 39 +++
 rtl/cond_unit.sv | 103 ++++++++++
 tb/tb_cond_unit.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/cond_unit_pkg.sv
// Shared definitions for the condition unit: ARM condition codes and NZCV/FlagW bit positions.
package cond_unit_pkg;

  localparam logic [3:0] COND_EQ   = 4'b0000;
  localparam logic [3:0] COND_NE   = 4'b0001;
  localparam logic [3:0] COND_CS   = 4'b0010;
  localparam logic [3:0] COND_CC   = 4'b0011;
  localparam logic [3:0] COND_MI   = 4'b0100;
  localparam logic [3:0] COND_PL   = 4'b0101;
  localparam logic [3:0] COND_VS   = 4'b0110;
  localparam logic [3:0] COND_VC   = 4'b0111;
  localparam logic [3:0] COND_HI   = 4'b1000;
  localparam logic [3:0] COND_LS   = 4'b1001;
  localparam logic [3:0] COND_GE   = 4'b1010;
  localparam logic [3:0] COND_LT   = 4'b1011;
  localparam logic [3:0] COND_GT   = 4'b1100;
  localparam logic [3:0] COND_LE   = 4'b1101;
  localparam logic [3:0] COND_AL   = 4'b1110;
  localparam logic [3:0] COND_RSVD = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/cond_unit_if.sv
// Decoder/ALU-to-condition-unit bundle: instruction strobes in, gated strobes and flag state out.
interface cond_unit_if;

  logic       ValidIn;
  logic       Stall;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;

  logic       ValidOut;
  logic       CondEx;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] Flags;
  logic       IllegalCond;

  modport master (
    output ValidIn, Stall, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    input  ValidOut, CondEx, PCSrc, RegWrite, MemWrite, Flags, IllegalCond
  );

  modport slave (
    input  ValidIn, Stall, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    output ValidOut, CondEx, PCSrc, RegWrite, MemWrite, Flags, IllegalCond
  );

endinterface

// File: rtl/cond_unit_check.sv
// Pure combinational ARM condition evaluator: Cond x NZCV -> pass. Reserved code 1111 never passes.
module cond_check
  import cond_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Condition unit: NZCV register, condition gating of write/branch strobes, one registered output stage.
// Optional executed/squashed counters are enabled by defining COND_STATS_EN.
module cond_unit
  import cond_unit_pkg::*;
#(
  parameter int         CNT_W     = 16,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic             clk,
  input  logic             rst_n,
  cond_unit_if.slave       bus
`ifdef COND_STATS_EN
  ,
  output logic [CNT_W-1:0] ExecCount,
  output logic [CNT_W-1:0] SquashCount
`endif
);

  if (CNT_W < 2) begin : g_bad_cnt_w
    $error("CNT_W must be at least 2");
  end

  logic       accept;
  logic       pass;
  logic [3:0] flags_reg;
  logic [3:0] flags_next;
  logic       valid_reg;
  logic       condex_reg;
  logic       pcsrc_reg;
  logic       regwrite_reg;
  logic       memwrite_reg;
  logic       illegal_reg;

  cond_check u_check (
    .cond (bus.Cond),
    .nzcv (flags_reg),
    .pass (pass)
  );

  assign accept = bus.ValidIn & ~bus.Stall;

  // FlagW bit gi owns the flag pair at [2*gi+1:2*gi]: FW_NZ -> {N,Z}, FW_CV -> {C,V}.
  for (genvar gi = 0; gi < 2; gi++) begin : g_flag_pair
    assign flags_next[2*gi +: 2] = (accept && pass && bus.FlagW[gi])
                                   ? bus.ALUFlags[2*gi +: 2]
                                   : flags_reg[2*gi +: 2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_reg    <= FLAGS_RST;
      valid_reg    <= 1'b0;
      condex_reg   <= 1'b0;
      pcsrc_reg    <= 1'b0;
      regwrite_reg <= 1'b0;
      memwrite_reg <= 1'b0;
      illegal_reg  <= 1'b0;
    end else begin
      flags_reg <= flags_next;
      if (accept && bus.Cond == COND_RSVD) begin
        illegal_reg <= 1'b1;
      end
      if (!bus.Stall) begin
        valid_reg    <= accept;
        condex_reg   <= accept & pass;
        pcsrc_reg    <= accept & pass & bus.PCS;
        regwrite_reg <= accept & pass & bus.RegW & ~bus.NoWrite;
        memwrite_reg <= accept & pass & bus.MemW;
      end
    end
  end

  assign bus.ValidOut    = valid_reg;
  assign bus.CondEx      = condex_reg;
  assign bus.PCSrc       = pcsrc_reg;
  assign bus.RegWrite    = regwrite_reg;
  assign bus.MemWrite    = memwrite_reg;
  assign bus.Flags       = flags_reg;
  assign bus.IllegalCond = illegal_reg;

`ifdef COND_STATS_EN
  logic [CNT_W-1:0] exec_cnt_reg;
  logic [CNT_W-1:0] squash_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_cnt_reg   <= '0;
      squash_cnt_reg <= '0;
    end else if (accept) begin
      if (pass && !(&exec_cnt_reg)) begin
        exec_cnt_reg <= exec_cnt_reg + 1'b1;
      end
      if (!pass && !(&squash_cnt_reg)) begin
        squash_cnt_reg <= squash_cnt_reg + 1'b1;
      end
    end
  end

  assign ExecCount   = exec_cnt_reg;
  assign SquashCount = squash_cnt_reg;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit: vector table, full condition sweep, stall/reserved/reset sequences.
module tb_cond_unit;
  import cond_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  cond_unit_if bus ();

`ifdef COND_STATS_EN
  logic [15:0] exec_count;
  logic [15:0] squash_count;
`endif

  cond_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef COND_STATS_EN
    ,
    .ExecCount   (exec_count),
    .SquashCount (squash_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pre;
    logic [3:0] cond;
    logic [1:0] fw;
    logic [3:0] alu;
    logic       pcs, regw, memw, nowrite;
    logic       ex, pc, rw, mw;
    logic [3:0] flags;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic stall, input logic [3:0] cond,
                       input logic [3:0] alu, input logic [1:0] fw, input logic pcs,
                       input logic regw, input logic memw, input logic nowrite);
    @(negedge clk);
    bus.ValidIn  = valid;
    bus.Stall    = stall;
    bus.Cond     = cond;
    bus.ALUFlags = alu;
    bus.FlagW    = fw;
    bus.PCS      = pcs;
    bus.RegW     = regw;
    bus.MemW     = memw;
    bus.NoWrite  = nowrite;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_flags(input logic [3:0] f);
    drive(1'b1, 1'b0, COND_AL, f, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  // Independent reference of the ARM condition table.
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z == 1'b1;
      4'd1:  return z == 1'b0;
      4'd2:  return cy == 1'b1;
      4'd3:  return cy == 1'b0;
      4'd4:  return n == 1'b1;
      4'd5:  return n == 1'b0;
      4'd6:  return v == 1'b1;
      4'd7:  return v == 1'b0;
      4'd8:  return (cy == 1'b1) && (z == 1'b0);
      4'd9:  return (cy == 1'b0) || (z == 1'b1);
      4'd10: return n ~^ v;
      4'd11: return n ^ v;
      4'd12: return (z == 1'b0) && (n ~^ v);
      4'd13: return (z == 1'b1) || (n ^ v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
`ifdef COND_STATS_EN
    logic [15:0] sq0, ex0;
`endif
    logic exp_pass;

    vecs[0]  = '{4'b0000, COND_AL, 2'b11, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100};
    vecs[1]  = '{4'b0100, COND_EQ, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100};
    vecs[2]  = '{4'b1001, COND_AL, 2'b10, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0101};
    vecs[3]  = '{4'b0000, COND_EQ, 2'b11, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[4]  = '{4'b1000, COND_LT, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1000};
    vecs[5]  = '{4'b1000, COND_GE, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000};
    vecs[6]  = '{4'b0100, COND_LE, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0100};
    vecs[7]  = '{4'b0100, COND_GT, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100};
    vecs[8]  = '{4'b0010, COND_HI, 2'b01, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001};
    vecs[9]  = '{4'b0110, COND_HI, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110};
    vecs[10] = '{4'b1001, COND_GT, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1001};
    vecs[11] = '{4'b0000, COND_NE, 2'b11, 4'b1010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1010};
    vecs[12] = '{4'b0011, COND_VS, 2'b01, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};

    bus.ValidIn = 1'b0; bus.Stall = 1'b0; bus.Cond = 4'd0; bus.ALUFlags = 4'd0;
    bus.FlagW = 2'b00; bus.PCS = 1'b0; bus.RegW = 1'b0; bus.MemW = 1'b0; bus.NoWrite = 1'b0;

    // Reset state
    step(); step();
    chk("rst_flags", bus.Flags, 4'b0000);
    chk("rst_valid", {3'b0, bus.ValidOut}, 4'd0);
    chk("rst_strobes", {bus.CondEx, bus.PCSrc, bus.RegWrite, bus.MemWrite}, 4'd0);
    chk("rst_illegal", {3'b0, bus.IllegalCond}, 4'd0);
    $display("reset: flags=%b valid=%b illegal=%b", bus.Flags, bus.ValidOut, bus.IllegalCond);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 13; i++) begin
      load_flags(vecs[i].pre);
      drive(1'b1, 1'b0, vecs[i].cond, vecs[i].alu, vecs[i].fw, vecs[i].pcs,
            vecs[i].regw, vecs[i].memw, vecs[i].nowrite);
      step();
      $display("vec %0d: pre=%b cond=%h fw=%b alu=%b -> ex=%b pc=%b rw=%b mw=%b flags=%b",
               i, vecs[i].pre, vecs[i].cond, vecs[i].fw, vecs[i].alu,
               bus.CondEx, bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.Flags);
      chk($sformatf("vec%0d_valid", i), {3'b0, bus.ValidOut}, 4'd1);
      chk($sformatf("vec%0d_strobes", i), {bus.CondEx, bus.PCSrc, bus.RegWrite, bus.MemWrite},
          {vecs[i].ex, vecs[i].pc, vecs[i].rw, vecs[i].mw});
      chk($sformatf("vec%0d_flags", i), bus.Flags, vecs[i].flags);
    end

    // Sweep all legal condition codes over all NZCV values
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 15; c++) begin
        load_flags(4'(f));
        drive(1'b1, 1'b0, 4'(c), 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        exp_pass = ref_pass(4'(c), 4'(f));
        chk($sformatf("sweep_f%0d_c%0d", f, c),
            {bus.CondEx, bus.PCSrc, bus.RegWrite, bus.MemWrite}, {4{exp_pass}});
      end
      $display("sweep: flags=%b done", 4'(f));
    end

    // Stall holds the output stage and flags while ValidIn is held
    load_flags(4'b0100);
    drive(1'b1, 1'b0, COND_AL, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b1, COND_AL, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      $display("stall %0d: valid=%b rw=%b mw=%b flags=%b", k, bus.ValidOut, bus.RegWrite, bus.MemWrite, bus.Flags);
      chk($sformatf("stall%0d_out", k), {bus.ValidOut, bus.CondEx, bus.RegWrite, bus.MemWrite}, 4'b1110);
      chk($sformatf("stall%0d_flags", k), bus.Flags, 4'b0100);
    end
    drive(1'b1, 1'b0, COND_AL, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    $display("unstall: valid=%b mw=%b flags=%b", bus.ValidOut, bus.MemWrite, bus.Flags);
    chk("unstall_out", {bus.ValidOut, bus.CondEx, bus.RegWrite, bus.MemWrite}, 4'b1101);
    chk("unstall_flags", bus.Flags, 4'b1111);
    drive(1'b0, 1'b0, COND_AL, 4'b0000, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    $display("bubble: valid=%b", bus.ValidOut);
    chk("bubble_out", {bus.ValidOut, bus.PCSrc, bus.RegWrite, bus.MemWrite}, 4'b0000);
    chk("bubble_flags", bus.Flags, 4'b1111);

    // Reserved code under stall is not accepted
    drive(1'b1, 1'b1, COND_RSVD, 4'b0000, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    $display("rsvd_stalled: illegal=%b flags=%b", bus.IllegalCond, bus.Flags);
    chk("rsvd_stall_illegal", {3'b0, bus.IllegalCond}, 4'd0);
    chk("rsvd_stall_flags", bus.Flags, 4'b1111);

    // Reserved code accepted: squash and sticky IllegalCond
`ifdef COND_STATS_EN
    sq0 = squash_count;
    ex0 = exec_count;
`endif
    drive(1'b1, 1'b0, COND_RSVD, 4'b0000, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    $display("rsvd: valid=%b ex=%b rw=%b illegal=%b flags=%b", bus.ValidOut, bus.CondEx, bus.RegWrite, bus.IllegalCond, bus.Flags);
    chk("rsvd_out", {bus.ValidOut, bus.CondEx, bus.RegWrite, bus.IllegalCond}, 4'b1001);
    chk("rsvd_flags", bus.Flags, 4'b1111);
`ifdef COND_STATS_EN
    checks++;
    if (squash_count !== sq0 + 16'd1 || exec_count !== ex0) begin
      errors++;
      $display("FAIL stats_rsvd: squash=%0d exec=%0d expected squash=%0d exec=%0d",
               squash_count, exec_count, sq0 + 16'd1, ex0);
    end
`endif
    drive(1'b1, 1'b0, COND_AL, 4'b1010, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    $display("after_rsvd: ex=%b rw=%b illegal=%b flags=%b", bus.CondEx, bus.RegWrite, bus.IllegalCond, bus.Flags);
    chk("sticky_out", {bus.ValidOut, bus.CondEx, bus.RegWrite, bus.IllegalCond}, 4'b1111);
    chk("sticky_flags", bus.Flags, 4'b1010);

    // Asynchronous reset mid-stream, no clock edge needed
    #2;
    rst_n = 1'b0;
    #1;
    $display("async_rst: flags=%b valid=%b illegal=%b", bus.Flags, bus.ValidOut, bus.IllegalCond);
    chk("arst_flags", bus.Flags, 4'b0000);
    chk("arst_out", {bus.ValidOut, bus.CondEx, bus.RegWrite, bus.IllegalCond}, 4'b0000);
    step();
    chk("arst_hold_flags", bus.Flags, 4'b0000);
    chk("arst_hold_valid", {3'b0, bus.ValidOut}, 4'd0);
    drive(1'b0, 1'b0, COND_AL, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", {3'b0, bus.ValidOut}, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
